bus_mem_ctrl: RTL

BUS_MEM_CTRL -- requirements
Module: bus_mem_ctrl

---
 rtl/bus_mem_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bus_mem_ctrl.sv
// rtl/bus_mem_ctrl.sv - word memory behind a shared tri-state bus with wait states
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   BUS       shared tri-state data bus (write data in, read data out during RESP)
//   Memread   read request from the master
//   Memwrite  write request from the master
//   Addr      byte address, word index = Addr[ADDR_W-1:2]
//   Ready     one-cycle completion strobe
//   Err       error qualifier, meaningful only while Ready is high
module bus_mem_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] BUS,
    input  logic              Memread,
    input  logic              Memwrite,
    input  logic [ADDR_W-1:0] Addr,
    output logic              Ready,
    output logic              Err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;

    // Bus-side sample stage: the FSM acts on the request as seen at the
    // previous edge, which gives the edge-k+1 acceptance timing.
    logic               r_smp_rd;
    logic               r_smp_wr;
    logic [IDX_W-1:0]   r_smp_idx;
    logic [DATA_W-1:0]  r_smp_bus;

    // Access in flight
    logic               r_rd;
    logic               r_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;

    logic               r_ready;
    logic               r_err_o;
    logic               r_drive;
    logic [DATA_W-1:0]  r_bus_out;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_from_idle;
    logic               w_accept;
    logic               w_abort;
    logic               w_enter_resp;
    logic               w_cur_rd;
    logic               w_cur_wr;
    logic [IDX_W-1:0]   w_cur_idx;
    logic [DATA_W-1:0]  w_cur_wdata;
    logic               w_oob;
    logic               w_err;
    logic               w_mem_we;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_unused_addr;

    assign w_unused_addr = ^Addr[1:0];

    // With WAIT_CYC=0 the response is formed on the accepting edge, so the
    // "current access" comes straight from the sample stage while in IDLE.
    always_comb begin
        w_from_idle  = (r_state == IDLE);
        w_cur_rd     = w_from_idle ? r_smp_rd  : r_rd;
        w_cur_wr     = w_from_idle ? r_smp_wr  : r_wr;
        w_cur_idx    = w_from_idle ? r_smp_idx : r_idx;
        w_cur_wdata  = w_from_idle ? r_smp_bus : r_wdata;
        w_accept     = w_from_idle && (r_smp_rd || r_smp_wr);
        w_abort      = (r_state == WAIT) && ((r_rd && !r_smp_rd) || (r_wr && !r_smp_wr));
        w_enter_resp = (w_accept && (WAIT_CYC == 0))
                    || ((r_state == WAIT) && !w_abort && (r_cnt == '0));
        w_oob        = (w_cur_idx >= IDX_LIMIT);
        w_err        = w_oob || (w_cur_rd && w_cur_wr);
        w_mem_we     = w_enter_resp && w_cur_wr && !w_err;
        w_rdata      = r_mem[w_cur_idx[MEM_AW-1:0]];
    end

    // Memory is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_cur_idx[MEM_AW-1:0]] <= w_cur_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_smp_rd  <= 1'b0;
            r_smp_wr  <= 1'b0;
            r_smp_idx <= '0;
            r_smp_bus <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_ready   <= 1'b0;
            r_err_o   <= 1'b0;
            r_drive   <= 1'b0;
            r_bus_out <= '0;
        end else begin
            r_smp_rd  <= Memread;
            r_smp_wr  <= Memwrite;
            r_smp_idx <= Addr[ADDR_W-1:2];
            r_smp_bus <= BUS;

            r_ready   <= 1'b0;
            r_err_o   <= 1'b0;
            r_drive   <= 1'b0;
            if (w_enter_resp) begin
                r_ready   <= 1'b1;
                r_err_o   <= w_err;
                // Out-of-range reads drive zeros; dual-request errors never drive.
                r_drive   <= w_cur_rd && !w_cur_wr;
                r_bus_out <= (w_cur_rd && !w_err) ? w_rdata : '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rd    <= r_smp_rd;
                        r_wr    <= r_smp_wr;
                        r_idx   <= r_smp_idx;
                        r_wdata <= r_smp_bus;
                        r_cnt   <= CNT_LOAD;
                        r_state <= (WAIT_CYC == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (w_abort) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign BUS   = r_drive ? r_bus_out : {DATA_W{1'bz}};
    assign Ready = r_ready;
    assign Err   = r_err_o;

endmodule
